// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words through a req/valid
// handshake and presents the instruction register split into opcode/operand.
module fetch_unit #(
  parameter int DATA_WIDTH    = 16,
  parameter int OPERAND_WIDTH = 11,
  parameter int OPCODE_WIDTH  = 5,
  parameter int ADDR_WIDTH    = 11
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
  input  logic                     mem_rvalid_i,
  output logic                     mem_req_o,
  output logic [ADDR_WIDTH-1:0]    mem_addr_o,
  input  logic                     stall_i,
  input  logic                     branch_en_i,
  input  logic [ADDR_WIDTH-1:0]    branch_target_i,
  output logic [OPCODE_WIDTH-1:0]  opcode_out_o,
  output logic [OPERAND_WIDTH-1:0] operand_out_o,
  output logic                     instr_valid_o,
  output logic                     halted_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   ir_q, ir_d;
  logic                    isHalt;

  assign isHalt = (ir_q[DATA_WIDTH-1 -: OPCODE_WIDTH] == {OPCODE_WIDTH{1'b1}});

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // IR only loads on the response edge, so it is frozen for the whole issue.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (mem_rvalid_i) begin
          ir_d    = mem_rdata_i;
          pc_d    = pc_q + ADDR_WIDTH'(1);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!stall_i) begin
          if (isHalt) begin
            state_d = HALTED;
          end else begin
            state_d = REQ;
            if (branch_en_i) pc_d = branch_target_i;
          end
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o     = (state_q == REQ);
    instr_valid_o = (state_q == ISSUE);
    halted_o      = (state_q == HALTED);
    mem_addr_o    = pc_q;
    opcode_out_o  = ir_q[DATA_WIDTH-1 -: OPCODE_WIDTH];
    operand_out_o = ir_q[OPERAND_WIDTH-1:0];
  end

endmodule
